// File: rtl/axi_lite_master.sv
// axi_lite_master: AXI4-Lite initiator with one outstanding transaction.
// A single-beat command is turned into an AW/W/B or AR/R exchange, and the
// result is returned on a valid/ready response port.
// Optional feature macro AXIM_TIMEOUT_EN adds a response watchdog of
// TIMEOUT_CYCLES cycles that ends a stuck transaction with resp 2'b11.
module axi_lite_master #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] AWADDR,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [31:0]       WDATA,
    output logic [3:0]        WSTRB,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [31:0]       RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RVALID,
    output logic              RREADY
);

    typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD, ST_RSP} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic              arvalid_q, arvalid_d, rready_q, rready_d;
    logic              aw_done_q, aw_done_d, w_done_q, w_done_d, b_done_q, b_done_d;
    logic              ar_done_q, ar_done_d, r_done_q, r_done_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;

`ifdef AXIM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             rsp_timeout_q, rsp_timeout_d;
`endif

    // A watchdog shorter than two cycles could fire before a zero-wait slave answers.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("axi_lite_master: TIMEOUT_CYCLES must be >= 2");
    end

    // READY/VALID are only ever high in the state that owns them, so handshakes need no state qualifier.
    assign aw_hs = awvalid_q & AWREADY;
    assign w_hs  = wvalid_q  & WREADY;
    assign b_hs  = bready_q  & BVALID;
    assign ar_hs = arvalid_q & ARREADY;
    assign r_hs  = rready_q  & RVALID;

    // Next-state and registered-output computation for the transaction FSM.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        b_done_d    = b_done_q;
        ar_done_d   = ar_done_q;
        r_done_d    = r_done_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
`ifdef AXIM_TIMEOUT_EN
        tmo_d         = tmo_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    rsp_write_d = cmd_write;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = '0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    b_done_d    = 1'b0;
                    ar_done_d   = 1'b0;
                    r_done_d    = 1'b0;
`ifdef AXIM_TIMEOUT_EN
                    tmo_d         = '0;
                    rsp_timeout_d = 1'b0;
`endif
                    if (cmd_write) begin
                        state_d   = ST_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD;
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                    end
                end
            end
            ST_WR: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Only the first B is kept; BRESP is parked directly in the response register.
                if (b_hs && !b_done_q) begin
                    b_done_d   = 1'b1;
                    rsp_resp_d = BRESP;
                end
                if (aw_done_d && w_done_d && b_done_d) begin
                    state_d     = ST_RSP;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                end
            end
            ST_RD: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    ar_done_d = 1'b1;
                end
                if (r_hs && !r_done_q) begin
                    r_done_d    = 1'b1;
                    rsp_rdata_d = RDATA;
                    rsp_resp_d  = RRESP;
                end
                if (ar_done_d && r_done_d) begin
                    state_d     = ST_RSP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef AXIM_TIMEOUT_EN
        // Watchdog: a normal completion in the same cycle takes precedence.
        if ((state_q == ST_WR || state_q == ST_RD) && state_d != ST_RSP) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_q == TMO_LAST) begin
                state_d       = ST_RSP;
                awvalid_d     = 1'b0;
                wvalid_d      = 1'b0;
                bready_d      = 1'b0;
                arvalid_d     = 1'b0;
                rready_d      = 1'b0;
                rsp_valid_d   = 1'b1;
                rsp_rdata_d   = '0;
                rsp_resp_d    = 2'b11;
                rsp_timeout_d = 1'b1;
            end
        end
`endif
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!ARESETn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            b_done_q    <= 1'b0;
            ar_done_q   <= 1'b0;
            r_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
`ifdef AXIM_TIMEOUT_EN
            tmo_q         <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            b_done_q    <= b_done_d;
            ar_done_q   <= ar_done_d;
            r_done_q    <= r_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
`ifdef AXIM_TIMEOUT_EN
            tmo_q         <= tmo_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    // cmd_ready is decoded straight from the state so it reads 1 while held in reset.
    assign cmd_ready = (state_q == ST_IDLE);
    assign AWADDR    = addr_q;
    assign ARADDR    = addr_q;
    assign AWVALID   = awvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
`ifdef AXIM_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: scoreboard bench for axi_lite_master with a behavioural
// AXI4-Lite register-file slave (configurable ready/response delays).
module tb_axi_lite_master;

    localparam int TMO = 16;

    logic        ACLK, ARESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    axi_lite_master #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- reference model and scoreboard ----------------
    typedef struct packed {
        logic        write;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        timeout;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] model_mem[256];

    // Register file semantics: word-aligned access only, byte-strobed writes, SLVERR otherwise.
    function automatic rsp_t model_apply(input bit wr, input logic [31:0] addr,
                                         input logic [31:0] data, input logic [3:0] strb);
        rsp_t r;
        int   idx;
        r.write   = wr;
        r.rdata   = 32'h0;
        r.resp    = 2'b00;
        r.timeout = 1'b0;
        idx = int'(addr[9:2]);
        if (addr[1:0] != 2'b00) begin
            r.resp = 2'b10;
        end else if (wr) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
        end else begin
            r.rdata = model_mem[idx];
        end
        return r;
    endfunction

    // ---------------- slave stimulus controls ----------------
    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    bit no_b = 0;
    int bp_mode = 0;        // 0: rsp_ready high, 1: random, 2: held low
    int b_hs_total = 0;
    logic [31:0] slv_mem[256];

    // Behavioural AXI4-Lite slave plus bus-protocol stability checks.
    initial begin : slave
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
        bit got_aw, got_w, b_pend, r_pend;
        bit aw_pend_p, w_pend_p, ar_pend_p, aw_hs_p, w_hs_p, ar_hs_p;
        int aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;
        logic [31:0] s_awaddr, s_wdata, s_rdata, awaddr_p, wdata_p, araddr_p;
        logic [3:0]  s_wstrb, wstrb_p;
        logic [1:0]  s_bresp, s_rresp;
        for (int i = 0; i < 256; i++) slv_mem[i] = 32'h0;
        {got_aw, got_w, b_pend, r_pend} = '0;
        {aw_pend_p, w_pend_p, ar_pend_p, aw_hs_p, w_hs_p, ar_hs_p} = '0;
        {aw_cnt, w_cnt, ar_cnt, b_wait, r_wait} = '0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                {got_aw, got_w, b_pend, r_pend} = '0;
                {aw_pend_p, w_pend_p, ar_pend_p, aw_hs_p, w_hs_p, ar_hs_p} = '0;
                {aw_cnt, w_cnt, ar_cnt} = '0;
            end else begin
                aw_hs = AWVALID && AWREADY;
                w_hs  = WVALID && WREADY;
                b_hs  = BVALID && BREADY;
                ar_hs = ARVALID && ARREADY;
                r_hs  = RVALID && RREADY;
                if (aw_pend_p) check("aw_hold", {AWVALID, AWADDR}, {1'b1, awaddr_p});
                if (w_pend_p)  check("w_hold", {WVALID, WSTRB, WDATA}, {1'b1, wstrb_p, wdata_p});
                if (ar_pend_p) check("ar_hold", {ARVALID, ARADDR}, {1'b1, araddr_p});
                if (aw_hs_p)   check("aw_drop", AWVALID, 1'b0);
                if (w_hs_p)    check("w_drop", WVALID, 1'b0);
                if (ar_hs_p)   check("ar_drop", ARVALID, 1'b0);
                aw_pend_p = AWVALID && !AWREADY; awaddr_p = AWADDR; aw_hs_p = aw_hs;
                w_pend_p  = WVALID && !WREADY;   wdata_p = WDATA; wstrb_p = WSTRB; w_hs_p = w_hs;
                ar_pend_p = ARVALID && !ARREADY; araddr_p = ARADDR; ar_hs_p = ar_hs;
                aw_cnt = (AWVALID && !aw_hs) ? aw_cnt + 1 : 0;
                w_cnt  = (WVALID && !w_hs) ? w_cnt + 1 : 0;
                ar_cnt = (ARVALID && !ar_hs) ? ar_cnt + 1 : 0;
                if (b_hs) begin b_pend = 0; b_hs_total++; end
                if (r_hs) r_pend = 0;
                if (aw_hs) begin got_aw = 1; s_awaddr = AWADDR; end
                if (w_hs)  begin got_w = 1; s_wdata = WDATA; s_wstrb = WSTRB; end
                if (got_aw && got_w) begin
                    got_aw = 0; got_w = 0;
                    if (!no_b) begin
                        if (s_awaddr[1:0] == 2'b00) begin
                            for (int b = 0; b < 4; b++)
                                if (s_wstrb[b]) slv_mem[s_awaddr[9:2]][8*b +: 8] = s_wdata[8*b +: 8];
                            s_bresp = 2'b00;
                        end else s_bresp = 2'b10;
                        b_pend = 1; b_wait = b_delay;
                    end
                end
                if (ar_hs) begin
                    if (ARADDR[1:0] == 2'b00) begin s_rdata = slv_mem[ARADDR[9:2]]; s_rresp = 2'b00; end
                    else begin s_rdata = 32'h0; s_rresp = 2'b10; end
                    r_pend = 1; r_wait = r_delay;
                end
            end
            @(posedge ACLK);
            #1;
            if (!ARESETn) begin
                AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
            end else begin
                AWREADY = (aw_cnt >= aw_delay);
                WREADY  = (w_cnt >= w_delay);
                ARREADY = (ar_cnt >= ar_delay);
                BVALID = 0;
                if (b_pend) begin
                    if (b_wait > 0) b_wait--;
                    else begin BVALID = 1; BRESP = s_bresp; end
                end
                RVALID = 0;
                if (r_pend) begin
                    if (r_wait > 0) r_wait--;
                    else begin RVALID = 1; RDATA = s_rdata; RRESP = s_rresp; end
                end
            end
        end
    end

    // Response-port backpressure.
    initial begin : rsp_driver
        rsp_ready = 0;
        forever begin
            @(posedge ACLK);
            #1;
            case (bp_mode)
                0:       rsp_ready = 1;
                1:       rsp_ready = ($urandom % 3) != 0;
                default: rsp_ready = 0;
            endcase
        end
    end

    // Scoreboard monitor: every consumed response is matched against the queue head.
    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge ACLK);
            if (ARESETn && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_write", rsp_write, e.write);
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_resp", rsp_resp, e.resp);
                    check("rsp_timeout", rsp_timeout, e.timeout);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_exp(input rsp_t e, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        int k = 0;
        exp_q.push_back(e);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        do begin @(negedge ACLK); k++; end while (!cmd_ready && k < 400);
        check("cmd_accept", cmd_ready, 1'b1);
        @(posedge ACLK);
        #1;
        cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    endtask

    task automatic send(input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
        send_exp(model_apply(wr, addr, data, strb), wr, addr, data, strb);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 2000) begin @(posedge ACLK); #1; k++; end
        check("drain", exp_q.size(), 0);
    endtask

    // Called right after the accept edge: checks the AXI valids of cycle 1 and rsp_valid arrival cycle.
    task automatic latency(input string name, input logic [4:0] exp_valids, input int exp_n);
        int n = 0;
        do begin
            @(negedge ACLK); n++;
            if (n == 1) check({name, "_valids"}, {AWVALID, WVALID, BREADY, ARVALID, RREADY}, exp_valids);
        end while (!rsp_valid && n < 100);
        check(name, n, exp_n);
        @(posedge ACLK);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        rsp_t        e;
        logic [35:0] held;
        logic [31:0] addr;
        int          k, b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
        ARESETn = 1;
        #1 ARESETn = 0;
        #1;
        check("rst_axi_valid_ready", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 5'b0);
        check("rst_addr", {AWADDR, ARADDR}, 64'h0);
        check("rst_wdata_wstrb", {WDATA, WSTRB}, 36'h0);
        check("rst_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_timeout, rsp_rdata}, 37'h0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        #2 ARESETn = 1;
        @(posedge ACLK);
        #1;

        // Write then read back, with minimum-latency checks on a zero-wait slave.
        send(1, 32'h10, 32'hDEADBEEF, 4'hF);
        latency("lat_write", 5'b11100, 3);
        drain();
        send(0, 32'h10, 32'h0, 4'h0);
        latency("lat_read", 5'b00011, 3);
        drain();

        // Byte-strobe merge and misaligned accesses.
        send(1, 32'h20, 32'h11223344, 4'hF);
        send(1, 32'h20, 32'hAABBCCDD, 4'b0101);
        send(0, 32'h20, 32'h0, 4'h0);
        send(0, 32'h6, 32'h0, 4'h0);
        send(1, 32'h7, 32'hCAFEF00D, 4'hF);
        drain();

        // Delayed AWREADY with response held off for five cycles.
        aw_delay = 3;
        bp_mode  = 2;
        @(posedge ACLK);
        #1;
        b0 = b_hs_total;
        send(1, 32'h30, 32'h5A5AA5A5, 4'hF);
        k = 0;
        do begin
            @(negedge ACLK); k++;
            check("busy_cmd_ready", cmd_ready, 1'b0);
        end while (!rsp_valid && k < 50);
        check("held_rsp_seen", rsp_valid, 1'b1);
        held = {rsp_write, rsp_resp, rsp_timeout, rsp_rdata};
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("held_rsp_valid", {rsp_valid, cmd_ready}, 2'b10);
            check("held_rsp_payload", {rsp_write, rsp_resp, rsp_timeout, rsp_rdata}, held);
        end
        bp_mode  = 0;
        aw_delay = 0;
        drain();
        check("one_b_accepted", b_hs_total - b0, 1);

        // Reset while ARVALID is pending: everything drops at once, no response follows.
        ar_delay = 10;
        send(0, 32'h10, 32'h0, 4'h0);
        k = 0;
        do begin @(negedge ACLK); k++; end while (!ARVALID && k < 20);
        check("arvalid_before_reset", ARVALID, 1'b1);
        #2 ARESETn = 0;
        #1;
        check("mid_rst_axi_valid_ready", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 5'b0);
        check("mid_rst_araddr", ARADDR, 32'h0);
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        void'(exp_q.pop_back());
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        #2 ARESETn = 1;
        ar_delay = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("no_rsp_after_reset", {rsp_valid, cmd_ready}, 2'b01);
        end
        @(posedge ACLK);
        #1;
        send(0, 32'h10, 32'h0, 4'h0);
        drain();

`ifdef AXIM_TIMEOUT_EN
        // Slave never answers B: watchdog completes the write with resp 2'b11.
        no_b = 1;
        e = '{write: 1'b1, rdata: 32'h0, resp: 2'b11, timeout: 1'b1};
        send_exp(e, 1, 32'h40, 32'h12345678, 4'hF);
        latency("lat_timeout", 5'b11100, TMO + 1);
        check("timeout_bready_low", BREADY, 1'b0);
        drain();
        no_b = 0;
        send(0, 32'h40, 32'h0, 4'h0);
        drain();
`endif

        // Randomised traffic with random slave delays and response backpressure.
        bp_mode = 1;
        for (int i = 0; i < 200; i++) begin
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
            r_delay  = $urandom_range(0, 3);
            addr = {22'h0, 4'($urandom_range(0, 15)), 2'b00, 4'h0};
            addr = addr >> 4;
            if ($urandom % 8 == 0) addr[1:0] = 2'($urandom_range(1, 3));
            send($urandom % 2 == 1, addr, $urandom, 4'($urandom));
        end
        drain();
        bp_mode = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
